// File: rtl/e_cycle_sequencer_pkg.sv
// e_seq_pkg
//   Shared types and default parameter values for the 6809 E/Q bus-cycle
//   sequencer.
//   - seq_state_t : bus-cycle tracker state, 2-bit encoded
//   - DEF_*       : default values for the sequencer parameters
package e_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    EHIGH = 2'd2,
    HOLD  = 2'd3
  } seq_state_t;

  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_HOLD_CYCLES  = 3;
  localparam int DEF_LATE_CYCLES  = 44;
  localparam int DEF_STALL_CYCLES = 255;

endpackage

// File: rtl/e_cycle_sequencer_sync_edge_det.sv
// sync_edge_det
//   Multi-stage synchroniser for one asynchronous level, plus rise/fall
//   detection against the previous synchronised value.
//   Ports:
//     i_clk    : fast clock
//     i_reset  : asynchronous active-high reset
//     i_d      : asynchronous input level
//     o_level  : synchronised level (last stage)
//     o_rise   : combinational, last stage went 0 -> 1
//     o_fall   : combinational, last stage went 1 -> 0
//   Edges are only reported once the pipeline holds real samples, so a
//   level that is already high when reset releases is not seen as a rise.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic [SYNC_STAGES:0]   vld_r;

  // Synchroniser chain, previous-value register and sample-valid tracker
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_r <= '0;
      prev_r <= 1'b0;
      vld_r  <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], i_d};
      prev_r <= sync_r[SYNC_STAGES-1];
      vld_r  <= {vld_r[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign o_level = sync_r[SYNC_STAGES-1];
  // vld_r top bit means prev_r also holds a post-reset sample
  assign o_rise  = vld_r[SYNC_STAGES] & o_level & ~prev_r;
  assign o_fall  = vld_r[SYNC_STAGES] & ~o_level & prev_r;

endmodule

// File: rtl/e_cycle_sequencer.sv
// e_cycle_sequencer
//   Tracks each 6809 bus cycle from the synchronised E and Q clocks and
//   drives the board buffer controls.
//   Ports:
//     i_clk, i_reset         : fast PLL clock, async active-high reset
//     i_e_clk, i_q_clk       : 6809 E and Q (asynchronous)
//     i_rw, i_sel            : R/W and board select, latched at cycle start
//     o_buf_oe, o_late_oe    : early / late buffer enables
//     o_dir                  : 1 = drive toward the CPU
//     o_wr_strobe            : one-cycle write-capture pulse on E fall
//     o_cycle_start          : one-cycle pulse on each E rise
//     o_stall                : E has not toggled for STALL_CYCLES clocks
//   All outputs are registered.
module e_cycle_sequencer
  import e_seq_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int LATE_CYCLES  = DEF_LATE_CYCLES,
  parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_e_clk,
  input  logic i_q_clk,
  input  logic i_rw,
  input  logic i_sel,
  output logic o_buf_oe,
  output logic o_late_oe,
  output logic o_dir,
  output logic o_wr_strobe,
  output logic o_cycle_start,
  output logic o_stall
);

  localparam int LW = $clog2(LATE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STALL_CYCLES + 1);
  localparam logic [LW-1:0] LATE_MAX  = LW'(LATE_CYCLES);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES);

  seq_state_t    state_r, state_nxt_s;
  logic          e_level_s, e_rise_s, e_fall_s;
  logic          q_level_s, q_rise_s, q_fall_s;
  logic          unused_s;
  logic [LW-1:0] late_cnt_r, late_nxt_s;
  logic [HW-1:0] hold_cnt_r, hold_nxt_s;
  logic [SW-1:0] stall_cnt_r, stall_nxt_s;
  logic          rw_r, sel_r, rw_nxt_s, sel_nxt_s;
  logic          buf_oe_nxt_s, late_oe_nxt_s, dir_nxt_s;
  logic          wr_nxt_s, cs_nxt_s, stall_flag_nxt_s;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_e_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_e_clk),
    .o_level (e_level_s),
    .o_rise  (e_rise_s),
    .o_fall  (e_fall_s)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_q_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_q_clk),
    .o_level (q_level_s),
    .o_rise  (q_rise_s),
    .o_fall  (q_fall_s)
  );

  // Only the Q rise and the E edges steer the sequencer
  assign unused_s = ^{e_level_s, q_level_s, q_fall_s};

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; an E rise always wins over Q rise or hold expiry
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (e_rise_s) begin
          state_nxt_s = EHIGH;
        end else if (q_rise_s) begin
          state_nxt_s = ADDR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ADDR: begin
        if (e_rise_s) begin
          state_nxt_s = EHIGH;
        end else begin
          state_nxt_s = ADDR;
        end
      end
      EHIGH: begin
        if (e_fall_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = EHIGH;
        end
      end
      HOLD: begin
        if (e_rise_s) begin
          state_nxt_s = EHIGH;
        end else if (hold_cnt_r == '0) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the rw/sel latch and the saturating counters
  always_comb begin
    rw_nxt_s    = rw_r;
    sel_nxt_s   = sel_r;
    late_nxt_s  = late_cnt_r;
    hold_nxt_s  = hold_cnt_r;
    stall_nxt_s = stall_cnt_r;
    // ADDR keeps the value captured at the Q rise
    if (((state_r == IDLE) && (e_rise_s || q_rise_s)) ||
        ((state_r == HOLD) && e_rise_s)) begin
      rw_nxt_s  = i_rw;
      sel_nxt_s = i_sel;
    end else begin
      rw_nxt_s  = rw_r;
      sel_nxt_s = sel_r;
    end
    if ((state_nxt_s == EHIGH) && (state_r != EHIGH)) begin
      late_nxt_s = '0;
    end else if ((state_r == EHIGH) && (late_cnt_r != LATE_MAX)) begin
      late_nxt_s = late_cnt_r + LW'(1);
    end else begin
      late_nxt_s = late_cnt_r;
    end
    if ((state_r == EHIGH) && e_fall_s) begin
      hold_nxt_s = HOLD_INIT;
    end else if ((state_r == HOLD) && (hold_cnt_r != '0)) begin
      hold_nxt_s = hold_cnt_r - HW'(1);
    end else begin
      hold_nxt_s = hold_cnt_r;
    end
    if (e_rise_s || e_fall_s) begin
      stall_nxt_s = '0;
    end else if (stall_cnt_r != STALL_MAX) begin
      stall_nxt_s = stall_cnt_r + SW'(1);
    end else begin
      stall_nxt_s = stall_cnt_r;
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rw_r        <= 1'b0;
      sel_r       <= 1'b0;
      late_cnt_r  <= '0;
      hold_cnt_r  <= '0;
      stall_cnt_r <= '0;
    end else begin
      rw_r        <= rw_nxt_s;
      sel_r       <= sel_nxt_s;
      late_cnt_r  <= late_nxt_s;
      hold_cnt_r  <= hold_nxt_s;
      stall_cnt_r <= stall_nxt_s;
    end
  end

  // Output decode from the upcoming state so the registered outputs
  // change on the same edge as the state
  always_comb begin
    buf_oe_nxt_s     = (state_nxt_s == EHIGH) || (state_nxt_s == HOLD);
    late_oe_nxt_s    = (state_nxt_s == HOLD) ||
                       ((state_nxt_s == EHIGH) && (late_nxt_s == LATE_MAX));
    dir_nxt_s        = buf_oe_nxt_s & rw_nxt_s & sel_nxt_s;
    wr_nxt_s         = (state_r == EHIGH) & e_fall_s & ~rw_r & sel_r;
    cs_nxt_s         = e_rise_s;
    stall_flag_nxt_s = (stall_nxt_s == STALL_MAX);
  end

  // Output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_buf_oe      <= 1'b0;
      o_late_oe     <= 1'b0;
      o_dir         <= 1'b0;
      o_wr_strobe   <= 1'b0;
      o_cycle_start <= 1'b0;
      o_stall       <= 1'b0;
    end else begin
      o_buf_oe      <= buf_oe_nxt_s;
      o_late_oe     <= late_oe_nxt_s;
      o_dir         <= dir_nxt_s;
      o_wr_strobe   <= wr_nxt_s;
      o_cycle_start <= cs_nxt_s;
      o_stall       <= stall_flag_nxt_s;
    end
  end

endmodule

// File: tb/tb_e_cycle_sequencer.sv
// tb_e_cycle_sequencer
//   Drives directed and randomized 6809 E/Q bus cycles into
//   e_cycle_sequencer and compares every output on every clock against a
//   bench-side reference built from detected-edge times (rise edge R, fall
//   edge F, last E edge), plus literal checks pinning the key timings.
module tb_e_cycle_sequencer;

  localparam int S  = 2;
  localparam int H  = 3;
  localparam int L  = 44;
  localparam int ST = 255;

  logic clk = 1'b0;
  logic i_reset, i_e_clk, i_q_clk, i_rw, i_sel;
  logic o_buf_oe, o_late_oe, o_dir, o_wr_strobe, o_cycle_start, o_stall;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model state
  int   n, r_at, f_at, last_evt;
  bit   act, fell, pend, prw, psel, lrd, lwr;
  bit   e_q[$];
  bit   q_q[$];
  logic [5:0] exp_v = 6'd0;

  always #5 clk = ~clk;

  e_cycle_sequencer #(
    .SYNC_STAGES (S),
    .HOLD_CYCLES (H),
    .LATE_CYCLES (L),
    .STALL_CYCLES(ST)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_e_clk      (i_e_clk),
    .i_q_clk      (i_q_clk),
    .i_rw         (i_rw),
    .i_sel        (i_sel),
    .o_buf_oe     (o_buf_oe),
    .o_late_oe    (o_late_oe),
    .o_dir        (o_dir),
    .o_wr_strobe  (o_wr_strobe),
    .o_cycle_start(o_cycle_start),
    .o_stall      (o_stall)
  );

  task automatic chk(input string name, input logic [5:0] act_v, input logic [5:0] req_v);
    chk_cnt++;
    if (act_v === req_v) pass_cnt++;
    else $display("FAIL %s: got %b, required %b at %0t", name, act_v, req_v, $time);
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Reference: edge m sample is queue[m-1]; a pin change sampled at edge m
  // is acted on at edge m+S, and only once two post-reset samples exist.
  initial begin
    bit er, ef, qr;
    forever begin
      @(posedge clk);
      if (i_reset) begin
        n = 0; last_evt = 0; r_at = 0; f_at = 0;
        act = 1'b0; fell = 1'b0; pend = 1'b0; lrd = 1'b0; lwr = 1'b0;
        e_q.delete(); q_q.delete();
        exp_v = 6'd0;
      end else begin
        n++;
        e_q.push_back(i_e_clk);
        q_q.push_back(i_q_clk);
        er = 1'b0; ef = 1'b0; qr = 1'b0;
        if (n >= S + 2) begin
          er = e_q[n-S-1] & ~e_q[n-S-2];
          ef = ~e_q[n-S-1] & e_q[n-S-2];
          qr = q_q[n-S-1] & ~q_q[n-S-2];
        end
        if (er) begin
          if (!act && pend) begin
            lrd = prw & psel; lwr = ~prw & psel;
          end else begin
            lrd = i_rw & i_sel; lwr = ~i_rw & i_sel;
          end
          act = 1'b1; fell = 1'b0; pend = 1'b0; r_at = n;
        end else if (act && !fell && ef) begin
          fell = 1'b1; f_at = n;
        end else if (!act && !pend && qr) begin
          pend = 1'b1; prw = i_rw; psel = i_sel;
        end
        if (act && fell && (n >= f_at + H)) act = 1'b0;
        if (er || ef) last_evt = n;
        exp_v = {act,
                 act && (fell || (n - r_at >= L)),
                 act && lrd,
                 act && fell && (n == f_at) && lwr,
                 er,
                 (n - last_evt) >= ST};
      end
    end
  end

  // Per-cycle comparison against the reference
  initial begin
    forever begin
      @(negedge clk);
      if (i_reset)
        chk("reset_outputs", {o_buf_oe, o_late_oe, o_dir, o_wr_strobe, o_cycle_start, o_stall}, 6'd0);
      else
        chk("outputs", {o_buf_oe, o_late_oe, o_dir, o_wr_strobe, o_cycle_start, o_stall}, exp_v);
    end
  end

  task automatic bus_cycle(input int qlead, input int ehigh, input int elow,
                           input logic rw, input logic sel, input bit chg);
    i_rw = rw; i_sel = sel;
    if (qlead > 0) begin
      i_q_clk = 1'b1;
      tick(qlead);
    end
    i_e_clk = 1'b1;
    i_q_clk = 1'b1;
    if (chg) begin
      i_rw  = 1'($urandom_range(1, 0));
      i_sel = 1'($urandom_range(1, 0));
    end
    tick(ehigh - ehigh / 2);
    i_q_clk = 1'b0;
    tick(ehigh / 2);
    i_e_clk = 1'b0;
    tick(elow);
  endtask

  initial begin
    i_reset = 1'b1; i_e_clk = 1'b0; i_q_clk = 1'b0; i_rw = 1'b1; i_sel = 1'b0;
    tick(3);
    chk("reset_state", {o_buf_oe, o_late_oe, o_dir, o_wr_strobe, o_cycle_start, o_stall}, 6'd0);
    i_reset = 1'b0;
    tick(10);

    // Normal read with literal timing pins
    i_rw = 1'b1; i_sel = 1'b1; i_q_clk = 1'b1;
    tick(3);
    i_e_clk = 1'b1;
    tick(2);
    chk("oe_before_R", {5'd0, o_buf_oe}, 6'd0);
    tick(1);
    chk("oe_cs_dir_at_R", {3'd0, o_buf_oe, o_cycle_start, o_dir}, 6'b000111);
    tick(43);
    chk("late_at_R+43", {5'd0, o_late_oe}, 6'd0);
    tick(1);
    chk("late_at_R+44", {5'd0, o_late_oe}, 6'd1);
    i_q_clk = 1'b0;
    tick(3);
    i_e_clk = 1'b0;
    tick(3);
    chk("read_at_F", {3'd0, o_buf_oe, o_late_oe, o_wr_strobe}, 6'b000110);
    tick(2);
    chk("read_at_F+2", {4'd0, o_buf_oe, o_late_oe}, 6'b000011);
    tick(1);
    chk("read_at_F+3", {4'd0, o_buf_oe, o_late_oe}, 6'd0);
    tick(5);

    // Write: strobe exactly at F
    i_rw = 1'b0; i_sel = 1'b1; i_q_clk = 1'b1;
    tick(3);
    i_e_clk = 1'b1;
    tick(30);
    i_q_clk = 1'b0;
    tick(20);
    i_e_clk = 1'b0;
    tick(2);
    chk("wr_before_F", {5'd0, o_wr_strobe}, 6'd0);
    tick(1);
    chk("wr_at_F", {4'd0, o_wr_strobe, o_dir}, 6'b000010);
    tick(1);
    chk("wr_at_F+1", {4'd0, o_wr_strobe, o_buf_oe}, 6'b000001);
    tick(2);
    chk("write_at_F+3", {4'd0, o_buf_oe, o_late_oe}, 6'd0);
    tick(5);

    // Short E: late enable only in the hold window
    i_rw = 1'b1; i_sel = 1'b0; i_q_clk = 1'b1;
    tick(2);
    i_e_clk = 1'b1;
    tick(19);
    chk("short_late_in_E", {4'd0, o_buf_oe, o_late_oe}, 6'b000010);
    tick(1);
    i_e_clk = 1'b0; i_q_clk = 1'b0;
    tick(3);
    chk("short_late_at_F", {5'd0, o_late_oe}, 6'd1);
    tick(3);
    chk("short_late_at_F+3", {5'd0, o_late_oe}, 6'd0);
    tick(5);

    // Back-to-back: E re-rises two cycles after F
    i_rw = 1'b1; i_sel = 1'b1; i_q_clk = 1'b1;
    tick(2);
    i_e_clk = 1'b1;
    tick(50);
    i_e_clk = 1'b0; i_q_clk = 1'b0;
    tick(2);
    i_e_clk = 1'b1; i_rw = 1'b0;
    tick(1);
    chk("b2b_at_F", {4'd0, o_buf_oe, o_late_oe}, 6'b000011);
    tick(1);
    chk("b2b_at_F+1", {5'd0, o_buf_oe}, 6'd1);
    tick(1);
    chk("b2b_new_R", {2'd0, o_buf_oe, o_late_oe, o_cycle_start, o_dir}, 6'b001010);
    tick(47);
    i_e_clk = 1'b0;
    tick(8);

    // Randomized cycles, including simultaneous Q/E, Q in hold, 1-cycle E
    for (int i = 0; i < 60; i++) begin
      bus_cycle(int'($urandom_range(5, 0)), int'($urandom_range(60, 1)),
                int'($urandom_range(10, 1)), 1'($urandom_range(1, 0)),
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end
    tick(10);

    // Stall: E held low
    i_e_clk = 1'b0; i_q_clk = 1'b0;
    tick(300);
    chk("stall_set", {5'd0, o_stall}, 6'd1);
    i_e_clk = 1'b1;
    tick(3);
    chk("stall_clear_cs", {4'd0, o_stall, o_cycle_start}, 6'b000001);
    tick(10);
    i_e_clk = 1'b0;
    tick(10);

    // Reset mid-EHIGH, released with E still high
    i_rw = 1'b1; i_sel = 1'b1; i_q_clk = 1'b1;
    tick(2);
    i_e_clk = 1'b1;
    tick(10);
    @(posedge clk);
    #2 i_reset = 1'b1;
    #1 chk("async_reset", {o_buf_oe, o_late_oe, o_dir, o_wr_strobe, o_cycle_start, o_stall}, 6'd0);
    tick(3);
    i_reset = 1'b0;
    tick(20);
    chk("no_rise_after_reset", {4'd0, o_buf_oe, o_cycle_start}, 6'd0);
    i_e_clk = 1'b0; i_q_clk = 1'b0;
    tick(10);
    bus_cycle(3, 50, 10, 1'b0, 1'b1, 1'b0);
    tick(10);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
